// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple-carry adder: CHUNK bits per clock, registered carry between chunks.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK:0]   chunk_res;
  logic             last_chunk;

  // One chunk of the ripple: operands come from the latched copies only.
  always_comb begin
    chunk_res = {1'b0, a_q[int'(idx_q)*CHUNK +: CHUNK]}
              + {1'b0, b_q[int'(idx_q)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx_q == IW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d = chunk_res[CHUNK];
        if (last_chunk) begin
          cout_d  = chunk_res[CHUNK];
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                 && (chunk_res[CHUNK-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule
